// File: rtl/race_start_sequencer.sv
// rtl/race_start_sequencer.sv - 3-2-1-GO race start countdown with false-start lockout
//
// Ports:
//   pclk              in   pixel clock, all logic on rising edge
//   rst               in   asynchronous active-low reset
//   enable            in   game_visible level; rising edge starts a countdown
//   key_in[3:0]       in   raw car controls {up,down,left,right}
//   controls_out[3:0] out  controls to car_ctl, live only in GO/RACE
//   timer_start       out  one-cycle pulse in the first GO cycle
//   race_active       out  high in GO and RACE
//   countdown_visible out  digit overlay select (COUNT)
//   countdown_digit   out  digit shown during COUNT, binary
//   go_visible        out  "GO" overlay select
//   false_start       out  cheater overlay select (PENALTY)
module race_start_sequencer #(
  parameter int STEP_TICKS    = 65_000_000,
  parameter int COUNT_FROM    = 3,
  parameter int PENALTY_STEPS = 2,
  parameter int CNT_W         = 27
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       enable,
  input  logic [3:0] key_in,
  output logic [3:0] controls_out,
  output logic       timer_start,
  output logic       race_active,
  output logic       countdown_visible,
  output logic [3:0] countdown_digit,
  output logic       go_visible,
  output logic       false_start
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_GO,
    S_RACE,
    S_PENALTY
  } state_t;

  localparam logic [CNT_W-1:0] TICK_LAST  = CNT_W'(STEP_TICKS - 1);
  localparam logic [3:0]       DIGIT_INIT = 4'(COUNT_FROM);
  localparam logic [3:0]       PEN_INIT   = 4'(PENALTY_STEPS);

  state_t           state, state_n;
  logic [CNT_W-1:0] tick, tick_n;
  logic [3:0]       digit, digit_n;
  logic [3:0]       pen, pen_n;
  logic             enable_q;
  logic             start;
  logic             step_end;

  logic [3:0] controls_n;
  logic       timer_start_n;
  logic       race_active_n;
  logic       countdown_visible_n;
  logic [3:0] countdown_digit_n;
  logic       go_visible_n;
  logic       false_start_n;

  assign start    = enable & ~enable_q;
  assign step_end = (tick == TICK_LAST);

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state             <= S_IDLE;
      tick              <= '0;
      digit             <= '0;
      pen               <= '0;
      enable_q          <= 1'b0;
      controls_out      <= '0;
      timer_start       <= 1'b0;
      race_active       <= 1'b0;
      countdown_visible <= 1'b0;
      countdown_digit   <= '0;
      go_visible        <= 1'b0;
      false_start       <= 1'b0;
    end else begin
      state             <= state_n;
      tick              <= tick_n;
      digit             <= digit_n;
      pen               <= pen_n;
      enable_q          <= enable;
      controls_out      <= controls_n;
      timer_start       <= timer_start_n;
      race_active       <= race_active_n;
      countdown_visible <= countdown_visible_n;
      countdown_digit   <= countdown_digit_n;
      go_visible        <= go_visible_n;
      false_start       <= false_start_n;
    end
  end

  always_comb begin
    state_n = state;
    digit_n = digit;
    pen_n   = pen;
    tick_n  = step_end ? '0 : tick + CNT_W'(1);

    if (!enable) begin
      // Dropping enable abandons the sequence; nothing carries over to the next start.
      state_n = S_IDLE;
      digit_n = '0;
      pen_n   = '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state_n = S_COUNT;
            digit_n = DIGIT_INIT;
          end
        end
        S_COUNT: begin
          // A key press beats a simultaneous step expiry, so GO can never be reached by cheating.
          if (key_in != 4'd0) begin
            state_n = S_PENALTY;
            pen_n   = PEN_INIT;
          end else if (step_end) begin
            if (digit > 4'd1) digit_n = digit - 4'd1;
            else              state_n = S_GO;
          end
        end
        S_GO: begin
          if (step_end) state_n = S_RACE;
        end
        S_RACE: begin
          state_n = S_RACE;
        end
        S_PENALTY: begin
          if (step_end) begin
            if (pen == 4'd1) begin
              state_n = S_COUNT;
              digit_n = DIGIT_INIT;
              pen_n   = '0;
            end else begin
              pen_n = pen - 4'd1;
            end
          end
        end
        default: state_n = S_IDLE;
      endcase
    end

    // Every state starts its step from zero; IDLE and RACE do not time anything.
    if (state_n != state || state_n == S_IDLE || state_n == S_RACE) tick_n = '0;

    // Outputs are decoded from the next state so the registers show the state just entered.
    controls_n          = '0;
    timer_start_n       = 1'b0;
    race_active_n       = 1'b0;
    countdown_visible_n = 1'b0;
    countdown_digit_n   = '0;
    go_visible_n        = 1'b0;
    false_start_n       = 1'b0;
    unique case (state_n)
      S_COUNT: begin
        countdown_visible_n = 1'b1;
        countdown_digit_n   = digit_n;
      end
      S_GO: begin
        go_visible_n  = 1'b1;
        race_active_n = 1'b1;
        controls_n    = key_in;
        timer_start_n = (state == S_COUNT);
      end
      S_RACE: begin
        race_active_n = 1'b1;
        controls_n    = key_in;
      end
      S_PENALTY: begin
        false_start_n = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_race_start_sequencer.sv
// tb/tb_race_start_sequencer.sv - scoreboard bench for race_start_sequencer
module tb_race_start_sequencer;

  logic       pclk;
  logic       rst;
  logic       enable;
  logic [3:0] key_in;
  logic [3:0] controls_out;
  logic       timer_start;
  logic       race_active;
  logic       countdown_visible;
  logic [3:0] countdown_digit;
  logic       go_visible;
  logic       false_start;

  race_start_sequencer #(
    .STEP_TICKS   (4),
    .COUNT_FROM   (3),
    .PENALTY_STEPS(2),
    .CNT_W        (3)
  ) dut (
    .pclk             (pclk),
    .rst              (rst),
    .enable           (enable),
    .key_in           (key_in),
    .controls_out     (controls_out),
    .timer_start      (timer_start),
    .race_active      (race_active),
    .countdown_visible(countdown_visible),
    .countdown_digit  (countdown_digit),
    .go_visible       (go_visible),
    .false_start      (false_start)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Output vector layout: {controls[3:0], timer_start, race_active, countdown_visible, digit[3:0], go_visible, false_start}
  typedef struct {
    int          due;
    logic [12:0] exp;
    string       nm;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  localparam logic [12:0] O_IDLE = 13'd0;
  localparam logic [12:0] O_PEN  = 13'b0000_0_0_0_0000_0_1;

  function automatic logic [12:0] o_cnt(input logic [3:0] d);
    return {4'b0000, 1'b0, 1'b0, 1'b1, d, 1'b0, 1'b0};
  endfunction

  function automatic logic [12:0] o_go(input logic [3:0] c, input logic ts);
    return {c, ts, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0};
  endfunction

  function automatic logic [12:0] o_race(input logic [3:0] c);
    return {c, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0};
  endfunction

  function automatic logic [12:0] actual();
    return {controls_out, timer_start, race_active, countdown_visible,
            countdown_digit, go_visible, false_start};
  endfunction

  always @(posedge pclk) cyc <= cyc + 1;

  // Monitor: each expectation is due in a specific cycle; compare it mid-cycle.
  always @(negedge pclk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      mon_e  = q.pop_front();
      checks = checks + 1;
      if (mon_e.due != cyc || actual() !== mon_e.exp) begin
        errors = errors + 1;
        $display("FAIL %s cycle %0d (due %0d): got %b expected %b",
                 mon_e.nm, cyc, mon_e.due, actual(), mon_e.exp);
      end
    end
  end

  // Apply inputs for one cycle and record what the outputs must show after the next edge.
  task automatic step(input logic en, input logic [3:0] key, input logic [12:0] ex, input string nm);
    exp_t e;
    enable = en;
    key_in = key;
    e.due  = cyc + 1;
    e.exp  = ex;
    e.nm   = nm;
    q.push_back(e);
    @(posedge pclk);
    #1;
  endtask

  task automatic countdown_to_go();
    step(1'b1, 4'd0, o_cnt(4'd3), "start");
    repeat (3) step(1'b1, 4'd0, o_cnt(4'd3), "cnt3");
    repeat (4) step(1'b1, 4'd0, o_cnt(4'd2), "cnt2");
    repeat (4) step(1'b1, 4'd0, o_cnt(4'd1), "cnt1");
  endtask

  task automatic direct_zero_check(input string nm);
    checks = checks + 1;
    if (actual() !== O_IDLE) begin
      errors = errors + 1;
      $display("FAIL %s: got %b expected %b", nm, actual(), O_IDLE);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst    = 1'b0;
    enable = 1'b0;
    key_in = 4'd0;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    #1;
    direct_zero_check("reset_outputs");
    rst = 1'b1;
    @(posedge pclk);
    #1;

    repeat (20) step(1'b0, 4'd0, O_IDLE, "idle");

    // Clean start through GO into RACE, then pass-through.
    countdown_to_go();
    step(1'b1, 4'd0, o_go(4'd0, 1'b1), "go_first");
    repeat (3) step(1'b1, 4'd0, o_go(4'd0, 1'b0), "go_hold");
    repeat (3) step(1'b1, 4'd0, o_race(4'd0), "race");
    step(1'b1, 4'b1010, o_race(4'b1010), "race_pass_1010");
    step(1'b1, 4'b0101, o_race(4'b0101), "race_pass_0101");
    step(1'b1, 4'd0, o_race(4'd0), "race_keys_off");

    // False start in digit 2, penalty ignores keys, countdown restarts at 3.
    step(1'b0, 4'd0, O_IDLE, "drop_in_race");
    step(1'b1, 4'd0, o_cnt(4'd3), "restart");
    repeat (3) step(1'b1, 4'd0, o_cnt(4'd3), "cnt3");
    repeat (2) step(1'b1, 4'd0, o_cnt(4'd2), "cnt2");
    step(1'b1, 4'b0001, O_PEN, "false_start");
    for (int i = 0; i < 7; i++)
      step(1'b1, (i % 2 == 0) ? 4'b1010 : 4'b1111, O_PEN, "penalty_hold");
    step(1'b1, 4'd0, o_cnt(4'd3), "penalty_exit");
    repeat (3) step(1'b1, 4'd0, o_cnt(4'd3), "cnt3");
    repeat (4) step(1'b1, 4'd0, o_cnt(4'd2), "cnt2");
    repeat (4) step(1'b1, 4'd0, o_cnt(4'd1), "cnt1");
    step(1'b1, 4'd0, o_go(4'd0, 1'b1), "go_after_penalty");

    // Abort in GO, then re-rise restarts at digit 3.
    step(1'b0, 4'd0, O_IDLE, "abort_go");
    step(1'b0, 4'd0, O_IDLE, "idle");

    // Key press on the final step expiry wins over GO.
    countdown_to_go();
    step(1'b1, 4'b0100, O_PEN, "key_on_expiry");
    step(1'b1, 4'd0, O_PEN, "penalty_hold");
    step(1'b0, 4'd0, O_IDLE, "drop_in_penalty");

    // Async reset while racing.
    countdown_to_go();
    step(1'b1, 4'd0, o_go(4'd0, 1'b1), "go_first");
    repeat (3) step(1'b1, 4'd0, o_go(4'd0, 1'b0), "go_hold");
    step(1'b1, 4'b0011, o_race(4'b0011), "race_pass_0011");
    @(negedge pclk);
    #2;
    rst = 1'b0;
    #1;
    direct_zero_check("async_reset_race");
    enable = 1'b0;
    @(posedge pclk);
    #1;
    rst = 1'b1;
    repeat (2) step(1'b0, 4'd0, O_IDLE, "idle_after_reset");

    @(negedge pclk);
    #1;
    checks = checks + 1;
    if (q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
